// File: rtl/conv_row_pe_if.sv
// rtl/conv_row_pe_if.sv - input beat and output sample handshake bundle for conv_row_pe
// slave is the PE side, master is the upstream/downstream side.
interface conv_row_pe_if #(
  parameter int DW = 8,
  parameter int K  = 3
);
  localparam int AW = 2*DW + $clog2(K);

  logic                 i_valid;
  logic                 o_ready;
  logic signed [DW-1:0] i_data;
  logic                 o_valid;
  logic                 i_ready;
  logic signed [AW-1:0] o_data;
  logic [4:0]           o_idx;

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_idx
  );

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data, o_idx
  );
endinterface

// File: rtl/conv_row_pe.sv
// rtl/conv_row_pe.sv - padded, strided 1D row convolution with weight reuse and output backpressure
// Define CONV_ROW_RELU_EN to clamp negative output sums to zero.
module conv_row_pe #(
  parameter int DW  = 8,
  parameter int W   = 16,
  parameter int K   = 3,
  parameter int PAD = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_start,
  input  logic         i_stride2,
  input  logic         i_keep_w,
  conv_row_pe_if.slave bus,
  output logic         o_busy,
  output logic         o_done
);
  localparam int AW  = 2*DW + $clog2(K);
  localparam int CW  = $clog2(W + 1);
  localparam int OCW = $clog2(W + K + 1);
  localparam int KI  = (K > 1) ? $clog2(K) : 1;
  localparam int XI  = (W > 1) ? $clog2(W) : 1;
  localparam int OW1 = W + 2*PAD - K + 1;
  localparam int OW2 = (W + 2*PAD - K) / 2 + 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_W  = 3'd1;
  localparam logic [2:0] S_LOAD_X  = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [OCW-1:0]       oc;
  logic [OCW-1:0]       ow;
  logic                 stride2;
  logic signed [DW-1:0] w [K];
  logic signed [DW-1:0] x [W];
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] y;
  logic signed [AW-1:0] o_data_r;
  logic                 o_valid_r;
  logic [4:0]           o_idx_r;
  logic                 adv;
  logic                 beat;

  assign ow   = stride2 ? OCW'(OW2) : OCW'(OW1);
  assign adv  = !o_valid_r || bus.i_ready;
  assign beat = bus.i_valid && bus.o_ready;

  assign bus.o_ready = (state == S_LOAD_W) || (state == S_LOAD_X);
  assign bus.o_valid = o_valid_r;
  assign bus.o_data  = o_data_r;
  assign bus.o_idx   = o_idx_r;
  assign o_busy      = (state != S_IDLE);
  assign o_done      = (state == S_DONE);

  // Taps landing in the padding region contribute nothing, so they are skipped.
  always_comb begin
    int pos;
    acc = '0;
    pos = 0;
    for (int k = 0; k < K; k++) begin
      pos = int'(oc) * (stride2 ? 2 : 1) + k - PAD;
      if (pos >= 0 && pos < W)
        acc = acc + AW'(w[k]) * AW'(x[pos[XI-1:0]]);
    end
`ifdef CONV_ROW_RELU_EN
    y = acc[AW-1] ? '0 : acc;
`else
    y = acc;
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      oc        <= '0;
      stride2   <= 1'b0;
      o_data_r  <= '0;
      o_valid_r <= 1'b0;
      o_idx_r   <= '0;
      for (int k = 0; k < K; k++) w[k] <= '0;
      for (int i = 0; i < W; i++) x[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            stride2 <= i_stride2;
            cnt     <= '0;
            oc      <= '0;
            state   <= i_keep_w ? S_LOAD_X : S_LOAD_W;
          end
        end
        S_LOAD_W: begin
          if (beat) begin
            w[cnt[KI-1:0]] <= bus.i_data;
            if (cnt == CW'(K - 1)) begin
              cnt   <= '0;
              state <= S_LOAD_X;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_LOAD_X: begin
          if (beat) begin
            x[cnt[XI-1:0]] <= bus.i_data;
            if (cnt == CW'(W - 1)) begin
              cnt   <= '0;
              oc    <= '0;
              state <= S_COMPUTE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          // The held sample only moves once downstream has taken it.
          if (adv) begin
            if (oc < ow) begin
              o_data_r  <= y;
              o_idx_r   <= 5'(oc);
              o_valid_r <= 1'b1;
              oc        <= oc + 1'b1;
            end else begin
              o_valid_r <= 1'b0;
              state     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/conv_row_pe.md
Name: conv_row_pe

Overview:
Parametrised 1D row-convolution engine for the conv stem. Computes one padded, strided output row from K weights and one W-wide activation row, supplied on a single input stream. Successor to the fixed 16-wide, 3-tap, stride-2 row PE, with these additions:
- parametrised width, row length, kernel size and padding
- run-time stride 1/2
- weight reuse across rows
- valid/ready handshakes on input and output, with backpressure

Parameters:
DW, 8, signed two's-complement data/weight width
W, 16, activation row length (≥ K)
K, 3, kernel taps (odd, 1..7)
PAD, 1, zero padding each side (0..K-1)
AW, 2*DW+$clog2(K), output accumulator width (derived, not overridable)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
i_start  in  1  start-of-row pulse; honoured only in IDLE
i_stride2  in  1  0 = stride 1, 1 = stride 2; sampled with accepted i_start
i_keep_w  in  1  1 = reuse stored weights, skip weight load; sampled with accepted i_start
i_valid  in  1  input beat valid
o_ready  out  1  input beat accepted when i_valid & o_ready
i_data  in  DW  weight or activation beat
o_valid  out  1  output sample valid
i_ready  in  1  downstream accepts output
o_data  out  AW  signed output sample
o_idx  out  5  index of current output sample
o_busy  out  1  high in any state other than IDLE
o_done  out  1  one-cycle pulse after last output accepted

Behaviour:
- Reset (async, rstn=0): state IDLE, weight regs, row buffer and counters cleared. o_ready=0, o_valid=0, o_data=0, o_idx=0, o_busy=0, o_done=0.
- States: IDLE, LOAD_W, LOAD_X, COMPUTE, DONE.
- IDLE transitions on i_start:
  - i_keep_w=1 → LOAD_X
  - i_keep_w=0 → LOAD_W
  - stride latched into S (1 or 2) at the same time.
- i_start outside IDLE is ignored.
- LOAD_W:
  - o_ready=1.
  - Accepted beats written to w[0..K-1] in order.
  - After K-th accepted beat → LOAD_X.
- LOAD_X:
  - o_ready=1.
  - Accepted beats written to x[0..W-1].
  - After W-th accepted beat → COMPUTE.
  - i_valid gaps stall the load without losing count.
- o_ready=0 in IDLE, COMPUTE and DONE; i_data is ignored in those states.
- Output count: OW = (W+2*PAD-K)/S + 1, integer division.
- Output formula: y[o] = Σ_{k=0..K-1} w[k]*xp[o*S+k-PAD].
  - xp[i] = x[i] for 0≤i<W, else 0 (padding).
  - Full-precision signed multiply and sum in AW bits; no saturation, no rounding.
- COMPUTE uses a single output register (o_valid/o_data/o_idx) with advance condition adv = !o_valid | i_ready:
  - On adv with oc<OW: load y[oc], o_idx=oc, o_valid=1, oc++.
  - On adv with oc==OW: o_valid=0, → DONE.
- COMPUTE latency: first o_valid 1 cycle after entering COMPUTE. With i_ready held high, one sample per cycle, OW consecutive cycles.
- Backpressure: while o_valid & !i_ready, o_data and o_idx hold stable.
- DONE: o_done=1 for one cycle → IDLE. Weights are retained; the x buffer is not cleared.
- Reset mid-operation returns to IDLE immediately. No partial output emitted after rstn release.
- i_keep_w=1 on the first row after reset uses the zeroed weights, so all outputs are 0. This is legal.

Optional Feature:
Macro CONV_ROW_RELU_EN.
- Defined: o_data = max(y[o], 0), i.e. negative sums output as 0 (ReLU fused).
- Undefined: raw signed sum.
- No timing or handshake difference either way.

Test Plan:
1. DW=8, W=16, K=3, PAD=1, stride1, w=[1,2,3], x[i]=i+1, i_ready=1 → 16 outputs on consecutive cycles: y[0]=8, y[k]=6k+8 for k=1..14, y[15]=47; o_done 1 cycle after last sample.
2. Same data, i_stride2=1 → 8 outputs y[o]=12o+8: 8,20,…,92; o_idx 0..7.
3. Signed extremes: w=[127,127,127], x all −128, stride1 → y[0]=y[15]=−32512, y[1..14]=−48768, no overflow in AW=18. With CONV_ROW_RELU_EN all outputs are 0.
4. Backpressure: case 1 with i_ready toggling 1,0,0,1,…; also i_valid gaps during LOAD_X → identical output sequence, each sample held stable while i_ready=0, no drop or duplicate.
5. Weight reuse: row 1 as case 1, then i_start with i_keep_w=1 and x[i]=1 → only 16 input beats accepted; y[0]=5, y[1..14]=6, y[15]=3.
6. Reset mid-LOAD_X after 5 beats → o_ready/o_valid/o_busy=0 at once. A new full row after release (w reloaded) gives case-1 results; i_start during COMPUTE has no effect.
